// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the E stage.
// The result is computed when the op is accepted, then held until the busy count expires.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  hilo_sel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MTHI  = 3'd1;
  localparam logic [2:0] OP_MTLO  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi, r_lo;
  logic [31:0]      r_pend_hi, r_pend_lo;
  logic             r_pend_wr;

  logic        w_op_ok, w_eff;
  logic [63:0] w_prod_u, w_prod_s;
  logic [31:0] w_b_div, w_mag_a, w_mag_b, w_uq, w_ur, w_sq, w_sr;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_res_wr;

  assign w_op_ok  = (op != 3'd0) && (op != 3'd7);
  assign w_eff    = start & ~cancel & ~r_busy & w_op_ok;
  assign md_stall = (start & w_op_ok) | r_busy;
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_prod_u = {32'd0, a} * {32'd0, b};
  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // Signed divide via magnitudes: avoids the INT_MIN/-1 overflow trap and divide-by-zero in the operator.
  assign w_b_div = (b == 32'd0) ? 32'd1 : b;
  assign w_mag_a = a[31] ? (~a + 32'd1) : a;
  assign w_mag_b = w_b_div[31] ? (~w_b_div + 32'd1) : w_b_div;
  assign w_uq    = w_mag_a / w_mag_b;
  assign w_ur    = w_mag_a % w_mag_b;
  assign w_sq    = (a[31] ^ w_b_div[31]) ? (~w_uq + 32'd1) : w_uq;
  assign w_sr    = a[31] ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b0;
    case (op)
      OP_MULTU: begin {w_res_hi, w_res_lo} = w_prod_u; w_res_wr = 1'b1; end
      OP_MULT:  begin {w_res_hi, w_res_lo} = w_prod_s; w_res_wr = 1'b1; end
      OP_DIVU:  begin
        w_res_lo = a / w_b_div;
        w_res_hi = a % w_b_div;
        w_res_wr = (b != 32'd0);
      end
      OP_DIV:   begin
        w_res_lo = w_sq;
        w_res_hi = w_sr;
        w_res_wr = (b != 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (hilo_sel)
      2'b10:   hilo_out = r_hi;
      2'b01:   hilo_out = r_lo;
      default: hilo_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_eff) begin
            case (op)
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_wr <= w_res_wr;
                r_cnt     <= (op == OP_MULTU || op == OP_MULT) ? MUL_LD : DIV_LD;
                r_busy    <= 1'b1;
                r_state   <= RUN;
              end
            endcase
          end
        end
        RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: each task drives one scenario and checks it inline.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [1:0]  hilo_sel;
  logic        busy, md_stall;
  logic [31:0] hilo_out, hi, lo;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .hilo_sel(hilo_sel), .busy(busy), .md_stall(md_stall),
    .hilo_out(hilo_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  task automatic idle_in();
    start = 1'b0; op = 3'd0; cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_in(); a = 32'd0; b = 32'd0; hilo_sel = 2'b10;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", md_stall); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mult();
    @(negedge clk); go(3'd4, 32'hFFFFFFFE, 32'd3); hilo_sel = 2'b10; #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL mult_stall0 got %b want 1", md_stall); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); idle_in(); #1;
      checks++; if (busy !== 1'b1 || md_stall !== 1'b1) begin errors++; $display("FAIL mult_busy c%0d got %b/%b want 1/1", i, busy, md_stall); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL mult_hold c%0d got %h_%h want 0_0", i, hi, lo); end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done_busy got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_res got %h_%h want ffffffff_fffffffa", hi, lo); end
    checks++; if (hilo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hilo_out got %h want ffffffff", hilo_out); end
  endtask

  task automatic test_multu();
    @(negedge clk); go(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk); idle_in();
    repeat (5) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_res got %h_%h want fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div();
    int nbusy = 0;
    @(negedge clk); go(3'd6, 32'hFFFFFFF9, 32'd2);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); idle_in();
      if (i == 2) cancel = 1'b1;
      #1;
      if (busy === 1'b1) nbusy++;
    end
    checks++; if (nbusy != 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", nbusy); end
    @(negedge clk); idle_in(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_done_busy got %b want 0", busy); end
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_res got hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
    @(negedge clk); go(3'd6, 32'd7, 32'hFFFFFFFE);
    @(negedge clk); idle_in();
    repeat (10) @(negedge clk);
    #1;
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin errors++; $display("FAIL div_pos_neg got hi=%h lo=%h want 00000001 fffffffd", hi, lo); end
    @(negedge clk); go(3'd6, 32'h80000000, 32'hFFFFFFFF);
    @(negedge clk); idle_in();
    repeat (10) @(negedge clk);
    #1;
    checks++; if (lo !== 32'h80000000 || hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf got hi=%h lo=%h want 00000000 80000000", hi, lo); end
  endtask

  task automatic test_div_zero();
    int nbusy = 0;
    @(negedge clk); go(3'd5, 32'd7, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); idle_in(); #1;
      if (busy === 1'b1) nbusy++;
    end
    checks++; if (nbusy != 10) begin errors++; $display("FAIL divz_busy_cycles got %0d want 10", nbusy); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_done_busy got %b want 0", busy); end
    checks++; if (hi !== 32'h00000000 || lo !== 32'h80000000) begin errors++; $display("FAIL divz_hold got hi=%h lo=%h want 00000000 80000000", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk); go(3'd1, 32'h12345678, 32'd0);
    @(negedge clk); go(3'd2, 32'h9ABCDEF0, 32'd0); #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h12345678) begin errors++; $display("FAIL mthi got busy=%b hi=%h want 0 12345678", busy, hi); end
    @(negedge clk); idle_in(); #1;
    checks++; if (busy !== 1'b0 || lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo got busy=%b lo=%h want 0 9abcdef0", busy, lo); end
    hilo_sel = 2'b10; #1;
    checks++; if (hilo_out !== 32'h12345678) begin errors++; $display("FAIL sel_hi got %h want 12345678", hilo_out); end
    hilo_sel = 2'b01; #1;
    checks++; if (hilo_out !== 32'h9ABCDEF0) begin errors++; $display("FAIL sel_lo got %h want 9abcdef0", hilo_out); end
    hilo_sel = 2'b11; #1;
    checks++; if (hilo_out !== 32'h0) begin errors++; $display("FAIL sel_11 got %h want 0", hilo_out); end
    hilo_sel = 2'b00; #1;
    checks++; if (hilo_out !== 32'h0) begin errors++; $display("FAIL sel_00 got %h want 0", hilo_out); end
  endtask

  task automatic test_cancel();
    @(negedge clk); go(3'd4, 32'd2, 32'd3); cancel = 1'b1; #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL cancel_stall got %b want 1", md_stall); end
    @(negedge clk); idle_in(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", busy); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL cancel_hold got %h_%h want 12345678_9abcdef0", hi, lo); end
  endtask

  task automatic test_reserved();
    @(negedge clk); go(3'd7, 32'd5, 32'd5); #1;
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL rsv_stall got %b want 0", md_stall); end
    @(negedge clk); idle_in(); #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL rsv_noop got busy=%b %h_%h", busy, hi, lo); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); go(3'd3, 32'd2, 32'd3);
    @(negedge clk); go(3'd3, 32'd5, 32'd7);
    @(negedge clk); go(3'd1, 32'hAAAA5555, 32'd0);
    @(negedge clk); idle_in();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL b2b_first got busy=%b %h_%h want 0 00000000_00000006", busy, hi, lo); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_second got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); go(3'd1, 32'hDEAD0000, 32'd0);
    @(negedge clk); go(3'd6, 32'd100, 32'd7);
    @(negedge clk); idle_in();
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || lo !== 32'd0) begin errors++; $display("FAIL rst_abort got busy=%b lo=%h want 0 0", busy, lo); end
    @(negedge clk); go(3'd3, 32'd2, 32'd3);
    @(negedge clk); idle_in();
    repeat (5) @(negedge clk);
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL rst_multu got %h_%h want 00000000_00000006", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_cancel();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
